// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the data-memory path: access sizes, sweep FSM states
// and the byte-lane enable helper used by store logic.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // Byte enables for an access of the given size starting at the given lane.
  // Always 8 bits wide; 32-bit memories use only the low four.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] mask;
    case (size)
      SZ_BYTE: mask = 8'h01 << lane;
      SZ_HALF: mask = 8'h03 << lane;
      SZ_WORD: mask = 8'h0F << lane;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed lanes out of a memory
// word, right-justifies them and sign- or zero-extends to the full width.
module load_align
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_BITS  = 2
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [BYTE_BITS-1:0]  lane,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [DATA_WIDTH-1:0] data
);

  localparam logic [DATA_WIDTH-1:0] MASK_8  = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] MASK_16 = DATA_WIDTH'(16'hFFFF);
  localparam logic [DATA_WIDTH-1:0] MASK_32 = DATA_WIDTH'(32'hFFFF_FFFF);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] low_mask;
  logic                  sign_bit;

  always_comb begin
    shifted  = word >> {lane, 3'b000};
    low_mask = {DATA_WIDTH{1'b1}};
    sign_bit = shifted[DATA_WIDTH-1];
    case (size)
      SZ_BYTE: begin low_mask = MASK_8;  sign_bit = shifted[7];  end
      SZ_HALF: begin low_mask = MASK_16; sign_bit = shifted[15]; end
      SZ_WORD: begin low_mask = MASK_32; sign_bit = shifted[31]; end
      default: ;
    endcase
    data = (shifted & low_mask) | ({DATA_WIDTH{sign_ext & sign_bit}} & ~low_mask);
  end

endmodule

// File: rtl/datamemory_bytelane.sv
// Byte-addressed synchronous data memory with lane-masked stores, sized/signed
// loads, misalignment rejection and an optional zeroing sweep after reset.
module datamemory_bytelane
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1,
  parameter int BYTE_BITS      = $clog2(DATA_WIDTH / 8)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic                            we,
  input  logic [1:0]                      size,
  input  logic                            signExt,
  input  logic [ADDR_WIDTH+BYTE_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]           dataIn,
  output logic [DATA_WIDTH-1:0]           dataOut,
  output logic                            valid,
  output logic                            misaligned,
  output logic                            ready,
  output logic                            busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam bit IS64   = (DATA_WIDTH == 64);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [0:0]            state_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;
  logic                  valid_reg;
  logic                  misaligned_reg;
  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic [BYTE_BITS-1:0]  lane_reg;
  logic [1:0]            size_reg;
  logic                  sext_reg;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [BYTE_BITS-1:0]  lane;
  logic                  aligned;
  logic                  accept;
  logic                  load_ok;
  logic                  store_ok;
  logic [7:0]            mask_full;
  logic                  unused_mask_bits;
  logic [NBYTES-1:0]     lane_we;
  logic [DATA_WIDTH-1:0] wdata;

  assign word_idx = address[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS];
  assign lane     = address[BYTE_BITS-1:0];
  assign ready    = (state_reg == ST_IDLE);
  assign busy     = (state_reg == ST_CLEAR);

  always_comb begin
    aligned = 1'b1;
    case (size)
      SZ_HALF:  aligned = ~address[0];
      SZ_WORD:  aligned = (address[1:0] == 2'b00);
      SZ_DWORD: aligned = IS64 && (address[2:0] == 3'b000);
      default:  aligned = 1'b1;
    endcase
  end

  assign accept   = req & ready;
  assign load_ok  = accept & aligned & ~we;
  assign store_ok = accept & aligned & we;

  assign mask_full        = lane_mask(size, 3'(lane));
  assign unused_mask_bits = ^mask_full;
  assign wdata            = dataIn << {lane, 3'b000};

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane_we
      assign lane_we[gi] = store_ok & mask_full[gi];
    end
  endgenerate

  // Array port kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == ST_CLEAR) begin
        mem[clr_cnt_reg] <= '0;
      end else begin
        for (int b = 0; b < NBYTES; b++) begin
          if (lane_we[b]) mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_reg    <= '0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      rd_word_reg    <= '0;
      lane_reg       <= '0;
      size_reg       <= SZ_BYTE;
      sext_reg       <= 1'b0;
    end else begin
      valid_reg      <= load_ok;
      misaligned_reg <= accept & ~aligned;
      if (state_reg == ST_CLEAR) begin
        clr_cnt_reg <= clr_cnt_reg + 1'b1;
        if (&clr_cnt_reg) state_reg <= ST_IDLE;
      end
      // Lane/size/sign are captured with the word so dataOut holds between loads.
      if (load_ok) begin
        rd_word_reg <= mem[word_idx];
        lane_reg    <= lane;
        size_reg    <= size;
        sext_reg    <= signExt;
      end
    end
  end

  load_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_BITS  (BYTE_BITS)
  ) u_load_align (
    .word     (rd_word_reg),
    .lane     (lane_reg),
    .size     (size_reg),
    .sign_ext (sext_reg),
    .data     (dataOut)
  );

  assign valid      = valid_reg;
  assign misaligned = misaligned_reg;

endmodule
